parallel_serial_framer: RTL

PARALLEL_SERIAL_FRAMER -- requirements
Module: parallel_serial_framer

---
 rtl/parallel_serial_framer.sv | 118 +++++++++++
 1 files changed

// File: rtl/parallel_serial_framer.sv
// Frames a 32-bit word onto a serial line: sync byte 0x5A, data MSB first,
// even-parity bit, then a two-cycle gap before the next request is accepted.
module parallel_serial_framer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        S_START,
  input  logic [31:0] P_IN,
  output logic        S_OUT,
  output logic        S_VALID,
  output logic        READY,
  output logic        DONE,
  output logic [7:0]  FRAME_CNT
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  logic [2:0]  r_state;
  logic [4:0]  r_bit_cnt;
  logic [38:0] r_shift;
  logic        r_parity;
  logic        r_sout;
  logic        r_valid;
  logic        r_ready;
  logic        r_done;
  logic [7:0]  r_frame_cnt;

  // The state names the phase currently on the line; the sync MSB is driven
  // on the accept edge itself, so the shifter holds only the remaining 39 bits.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_sout      <= 1'b0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (S_START) begin
            r_ready   <= 1'b0;
            r_state   <= SYNC;
            r_bit_cnt <= '0;
            r_shift   <= {SYNC_BYTE[6:0], P_IN};
            r_parity  <= ^P_IN;
            r_sout    <= SYNC_BYTE[7];
            r_valid   <= 1'b1;
          end
        end
        SYNC: begin
          r_sout  <= r_shift[38];
          r_shift <= {r_shift[37:0], 1'b0};
          if (r_bit_cnt == 5'd7) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        DATA: begin
          if (r_bit_cnt == 5'd31) begin
            r_sout    <= r_parity;
            r_state   <= PARITY;
            r_bit_cnt <= '0;
          end else begin
            r_sout    <= r_shift[38];
            r_shift   <= {r_shift[37:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        PARITY: begin
          r_sout      <= 1'b0;
          r_valid     <= 1'b0;
          r_done      <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 8'd1;
          r_state     <= GAP;
          r_bit_cnt   <= '0;
        end
        GAP: begin
          r_done <= 1'b0;
          if (r_bit_cnt == 5'd1) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_bit_cnt <= '0;
          r_sout    <= 1'b0;
          r_valid   <= 1'b0;
          r_ready   <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign S_OUT     = r_sout;
  assign S_VALID   = r_valid;
  assign READY     = r_ready;
  assign DONE      = r_done;
  assign FRAME_CNT = r_frame_cnt;

endmodule
